multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle MIPS control FSM; the initiator side of the ALU interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 3-bit ALU control code and datapath enables, and consumes the ALU Zero flag for beq.
- Sits between the instruction register (opcode/funct fields) and the datapath muxes, register file, memory and ALU.

Parameters:
TRAP_ON_ILLEGAL, 0, 1 = an illegal opcode/funct enters HALT until reset; 0 = it returns to FETCH.

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
opcode  input  6  IR[31:26], stable from DECODE until the next FETCH
funct  input  6  IR[5:0]
Zero  input  1  ALU zero flag
ALUOp  output  3  ALU code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
PCWrite  output  1  PC load enable
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
MemWrite  output  1  data memory write
IRWrite  output  1  instruction register load
RegDst  output  1  write register: 0 = rt, 1 = rd
MemtoReg  output  1  write data: 0 = ALUOut, 1 = MDR
RegWrite  output  1  register file write
ALUSrcA  output  1  ALU A: 0 = PC, 1 = rs
ALUSrcB  output  2  ALU B: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = immediate shifted left 2
PCSrc  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
illegal_op  output  1  one-cycle pulse on an undecodable instruction
state_dbg  output  4  current state encoding

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: on the reset edge, state := FETCH.
  - While reset is high, PCWrite, IRWrite, MemWrite, RegWrite and illegal_op are forced to 0. Other outputs follow state.
  - Reset mid-instruction abandons it; no further writes occur.
- Output defaults: every output not listed for a state is 0, except ALUOp = 010.
- Output timing: outputs are combinational from state (Moore). Exceptions:
  - EXECUTE ALUOp decodes funct.
  - BRANCH PCWrite = Zero.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, HALT 12.
- States (outputs -> next state):
  - FETCH: ALUSrcB=01, ALUOp=010, IRWrite=1, PCWrite=1 -> DECODE.
  - DECODE: ALUSrcB=11, ALUOp=010 (branch target into ALUOut). Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - anything else -> illegal
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=010 -> MEMREAD if opcode=100011, else MEMWRITE.
  - MEMREAD: IorD=1 -> MEMWB.
  - MEMWB: MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWRITE: IorD=1, MemWrite=1 -> FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp from funct:
    - 100000 -> 010
    - 100010 -> 110
    - 100100 -> 000
    - 100101 -> 001
    - 101010 -> 111
    - next state ALUWB; any other funct -> illegal.
  - ALUWB: RegDst=1, RegWrite=1 -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=110, PCSrc=01, PCWrite=Zero -> FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=010 -> ADDIWB.
  - ADDIWB: RegWrite=1 (RegDst=0, MemtoReg=0) -> FETCH.
  - JUMP: PCSrc=10, PCWrite=1 -> FETCH.
  - HALT: all enables 0 -> HALT. Only reset exits.
- Illegal handling:
  - illegal_op=1 during the decoding cycle (DECODE or EXECUTE).
  - No RegWrite, MemWrite or PCWrite is issued for the illegal instruction.
  - Next state is HALT if TRAP_ON_ILLEGAL=1, else FETCH.
- Latency in cycles, counted FETCH to next FETCH:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal opcode 2; illegal funct 3.
- Undefined state encodings (13-15) -> FETCH on the next edge, all enables 0.
- Zero is sampled only in BRANCH; it is ignored in all other states.

Test Plan:
- Reset 2 cycles, release, opcode=000000 -> FETCH at release: PCWrite=1, IRWrite=1, ALUSrcB=01, ALUOp=010; the next cycle is DECODE (state_dbg=1). No enables during reset.
- lw (opcode=100011) -> state_dbg 0,1,2,3,4,0. MEMREAD IorD=1; MEMWB RegWrite=1, MemtoReg=1, RegDst=0. 5 cycles total.
- R-type with funct=100010, 101010, 100101 -> EXECUTE ALUOp 110, 111, 001. ALUWB RegDst=1, RegWrite=1.
- beq with Zero=1 -> BRANCH PCWrite=1, PCSrc=01, ALUOp=110. Repeat with Zero=0 -> PCWrite=0, back to FETCH.
- opcode=111111: with TRAP_ON_ILLEGAL=0 -> illegal_op pulse in DECODE, then FETCH. With TRAP_ON_ILLEGAL=1 -> state_dbg=12 held for 10 cycles until reset.
- sw, with reset asserted in the MEMADR cycle -> MemWrite never 1; FETCH on the next edge.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: steps each instruction through
// fetch/decode/execute/memory/writeback and drives ALU control and
// datapath enables. Outputs are Moore from state, except the EXECUTE
// ALU code (from funct) and the BRANCH PC write (from Zero).
module multicycle_control #(
  parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic [2:0] ALUOp,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDIEX   = 4'd9;
  localparam logic [3:0] S_ADDIWB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [3:0] S_ILLEGAL_NEXT = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_pcwrite;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_illegal;

  // State register; synchronous reset returns to FETCH.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state and output decode.
  always_comb begin
    w_next     = S_FETCH;
    ALUOp      = ALU_ADD;
    w_pcwrite  = 1'b0;
    IorD       = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    w_regwrite = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          6'b100011, 6'b101011: w_next = S_MEMADR;
          6'b000000:            w_next = S_EXECUTE;
          6'b000100:            w_next = S_BRANCH;
          6'b001000:            w_next = S_ADDIEX;
          6'b000010:            w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_ILLEGAL_NEXT;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (opcode == 6'b100011) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        w_next  = S_ALUWB;
        case (funct)
          6'b100000: ALUOp = ALU_ADD;
          6'b100010: ALUOp = ALU_SUB;
          6'b100100: ALUOp = ALU_AND;
          6'b100101: ALUOp = ALU_OR;
          6'b101010: ALUOp = ALU_SLT;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_ILLEGAL_NEXT;
          end
        endcase
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALU_SUB;
        PCSrc     = 2'b01;
        w_pcwrite = Zero;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Write enables and the illegal pulse are suppressed while reset is held.
  always_comb begin
    PCWrite    = w_pcwrite  & ~reset;
    MemWrite   = w_memwrite & ~reset;
    IRWrite    = w_irwrite  & ~reset;
    RegWrite   = w_regwrite & ~reset;
    illegal_op = w_illegal  & ~reset;
    state_dbg  = r_state;
  end

endmodule
